// File: rtl/dvp_pattern_tx.sv
// rtl/dvp_pattern_tx.sv - DVP (cam_vsync/cam_href/cam_data) RGB565 colour-bar frame generator
// DVP_TX_PIX_IN_EN: adds pix_req/pix_data so pixel words come from an external source instead of bars.
module dvp_pattern_tx #(
   parameter int H_ACT   = 640,
   parameter int H_BLANK = 160,
   parameter int V_ACT   = 480,
   parameter int VSYNC_W = 4,
   parameter int V_BP    = 8,
   parameter int V_FP    = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tx_en,
`ifdef DVP_TX_PIX_IN_EN
   output logic        pix_req,
   input  logic [15:0] pix_data,
`endif
   output logic        cam_vsync,
   output logic        cam_href,
   output logic [7:0]  cam_data,
   output logic        frame_done,
   output logic        busy
);
   localparam int LINE = 2 * H_ACT + H_BLANK;
   localparam int HW   = $clog2(LINE);
   localparam int VM_A = (V_ACT > V_BP) ? V_ACT : V_BP;
   localparam int VM_B = (V_FP > VSYNC_W) ? V_FP : VSYNC_W;
   localparam int VW   = $clog2(((VM_A > VM_B) ? VM_A : VM_B) + 1);
   localparam logic [HW-1:0] H_LAST = HW'(LINE - 1);
   localparam logic [HW-1:0] H_ACT2 = HW'(2 * H_ACT);

   typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

   state_t        state, nxt_state;
   logic [HW-1:0] h_cnt, nxt_h;
   logic [VW-1:0] v_cnt, nxt_v;
   logic          nxt_act;
   logic [15:0]   pix;

   function automatic logic [VW-1:0] v_last(input state_t s);
      case (s)
         VSYNC:   v_last = VW'(VSYNC_W - 1);
         VBP:     v_last = VW'(V_BP - 1);
         ACTIVE:  v_last = VW'(V_ACT - 1);
         VFP:     v_last = VW'(V_FP - 1);
         default: v_last = '0;
      endcase
   endfunction

   // Outputs are registered from the position of the *next* cycle, so every
   // output lines up with state/h_cnt/v_cnt of the cycle it is shown in.
   always_comb begin
      nxt_state = state;
      nxt_h     = h_cnt;
      nxt_v     = v_cnt;
      if (state == IDLE) begin
         if (tx_en) nxt_state = VSYNC;
      end else if (h_cnt != H_LAST) begin
         nxt_h = h_cnt + HW'(1);
      end else begin
         nxt_h = '0;
         if (v_cnt != v_last(state)) begin
            nxt_v = v_cnt + VW'(1);
         end else begin
            nxt_v = '0;
            case (state)
               VSYNC:   nxt_state = (V_BP == 0) ? ACTIVE : VBP;
               VBP:     nxt_state = ACTIVE;
               ACTIVE:  nxt_state = VFP;
               default: nxt_state = tx_en ? VSYNC : IDLE;
            endcase
         end
      end
      nxt_act = (nxt_state == ACTIVE) && (nxt_h < H_ACT2);
   end

`ifndef DVP_TX_PIX_IN_EN
   localparam int BAR_W = H_ACT / 8;
   localparam int PW    = $clog2(BAR_W + 1);
   localparam int XW    = $clog2(H_ACT + 1);
   localparam logic [PW-1:0] PX_LAST = PW'(BAR_W - 1);

   logic          byte_sel;
   logic [XW-1:0] x_cnt, nxt_x;
   logic [PW-1:0] bar_px, nxt_px;
   logic [2:0]    bar_idx, nxt_bar;

   always_comb begin
      nxt_x   = x_cnt;
      nxt_px  = bar_px;
      nxt_bar = bar_idx;
      if (nxt_h == '0) begin
         nxt_x   = '0;
         nxt_px  = '0;
         nxt_bar = '0;
      end else if (byte_sel && nxt_act) begin
         nxt_x = x_cnt + XW'(1);
         if (bar_px == PX_LAST) begin
            nxt_px  = '0;
            nxt_bar = bar_idx + 3'd1;
         end else begin
            nxt_px = bar_px + PW'(1);
         end
      end
      case (nxt_bar)
         3'd0:    pix = 16'hFFFF;
         3'd1:    pix = 16'hFFE0;
         3'd2:    pix = 16'h07FF;
         3'd3:    pix = 16'h07E0;
         3'd4:    pix = 16'hF81F;
         3'd5:    pix = 16'hF800;
         3'd6:    pix = 16'h001F;
         default: pix = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_sel <= 1'b0;
         x_cnt    <= '0;
         bar_px   <= '0;
         bar_idx  <= '0;
      end else begin
         byte_sel <= nxt_h[0];
         x_cnt    <= nxt_x;
         bar_px   <= nxt_px;
         bar_idx  <= nxt_bar;
      end
   end
`else
   logic [7:0] pix_lo;
   logic       nxt_req, line_end, last_line;

   // Request in the cycle before each even byte; the high byte goes out
   // straight from pix_data, the low byte is held for the following cycle.
   always_comb begin
      line_end  = (nxt_h == H_LAST);
      last_line = (nxt_v == v_last(nxt_state));
      nxt_req   = ((nxt_state == ACTIVE) && nxt_h[0] && (nxt_h < H_ACT2 - HW'(1))) ||
                  (line_end && (((nxt_state == ACTIVE) && !last_line) ||
                                ((nxt_state == VBP) && last_line) ||
                                ((V_BP == 0) && (nxt_state == VSYNC) && last_line)));
      pix       = {pix_data[15:8], pix_lo};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_req <= 1'b0;
         pix_lo  <= '0;
      end else begin
         pix_req <= nxt_req;
         if (pix_req) pix_lo <= pix_data[7:0];
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         h_cnt      <= '0;
         v_cnt      <= '0;
         cam_vsync  <= 1'b0;
         cam_href   <= 1'b0;
         cam_data   <= 8'h00;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= nxt_state;
         h_cnt      <= nxt_h;
         v_cnt      <= nxt_v;
         cam_vsync  <= (nxt_state == VSYNC);
         cam_href   <= nxt_act;
         cam_data   <= nxt_act ? (nxt_h[0] ? pix[7:0] : pix[15:8]) : 8'h00;
         frame_done <= (nxt_state == VFP) && (nxt_v == v_last(VFP)) && (nxt_h == H_LAST);
         busy       <= (nxt_state != IDLE);
      end
   end
endmodule
